// File: rtl/game_pkg.sv
// game_pkg: shared encodings and constants for the game state controller.
// Scene codes double as the FSM state encoding.
package game_pkg;

  typedef enum logic [1:0] {
    SCENE_TITLE = 2'b00,
    SCENE_PLAY  = 2'b01,
    SCENE_WIN   = 2'b10,
    SCENE_LOSE  = 2'b11
  } scene_t;

  localparam int          INV_FRAMES    = 120;
  localparam int          TIMER_W       = 7;
  localparam int          MAX_LIFE      = 3;
  localparam int unsigned PTS_ENM_KILL  = 10;
  localparam int unsigned PTS_BOSS_HIT  = 1;
  localparam int unsigned PTS_BOSS_DEAD = 100;

  typedef logic [3:0]       bcd_digit_t;
  typedef bcd_digit_t [3:0] bcd_score_t;

  // Converts a small binary point total (0..9999) into four BCD digits.
  function automatic bcd_score_t points_to_bcd(input int unsigned pts);
    bcd_score_t r;
    r[0] = 4'(pts % 10);
    r[1] = 4'((pts / 10) % 10);
    r[2] = 4'((pts / 100) % 10);
    r[3] = 4'((pts / 1000) % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_add.sv
// bcd_score_add: 4-digit BCD adder that clamps at 9999 instead of wrapping.
// Purely combinational.
module bcd_score_add
  import game_pkg::*;
(
  input  bcd_score_t score,
  input  bcd_score_t inc,
  output bcd_score_t result
);

  logic [4:0] dsum;
  logic       carry;

  // Ripple digit-by-digit with decimal carry; a carry out of the top digit saturates.
  always_comb begin
    result = '0;
    dsum   = '0;
    carry  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dsum  = {1'b0, score[i]} + {1'b0, inc[i]} + {4'b0000, carry};
      carry = (dsum > 5'd9);
      result[i] = carry ? 4'(dsum - 5'd10) : dsum[3:0];
    end
    if (carry) begin
      result = {4'd9, 4'd9, 4'd9, 4'd9};
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: scene sequencing, lives, invincibility timer and BCD score.
// Optional macro GSC_INVULN_BLINK_EN: the player sprite blinks (timer bit 3)
// while invincible; without it the sprite stays visible throughout PLAY.
//
// state       | meaning
// ------------+----------------------------------------------
// SCENE_TITLE | waiting for start, score of last game shown
// SCENE_PLAY  | game running, scoring and hits accepted
// SCENE_WIN   | boss destroyed, waiting for start
// SCENE_LOSE  | last life lost, waiting for start
module game_state_ctrl
  import game_pkg::*;
(
  input  logic       clk_25m,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       enm_kill,
  input  logic       boss_hit,
  input  logic       boss_dead,
  input  logic       player_hit,
  output logic [1:0] scene,
  output logic [1:0] life,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [3:0] score3,
  output logic       reimuE,
  output logic       game_rst
);

  scene_t               state;
  bcd_score_t           score_q;
  bcd_score_t           inc_bcd;
  bcd_score_t           score_sum;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;
  logic                 start_d;
  logic                 start_armed;
  logic                 start_pulse;
  logic                 hit_ok;
  logic                 vis_nxt;
  int unsigned          pts;

  assign scene  = state;
  assign score0 = score_q[0];
  assign score1 = score_q[1];
  assign score2 = score_q[2];
  assign score3 = score_q[3];

  // Start edge detect; the armed flag keeps a level held through reset from counting.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      start_d     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_d     <= start_btn;
      start_armed <= 1'b1;
    end
  end

  // Start and accepted-hit qualifiers.
  always_comb begin
    start_pulse = start_armed & start_btn & ~start_d;
    hit_ok      = (state == SCENE_PLAY) & player_hit & ~boss_dead & (timer == '0);
  end

  // Sum of this cycle's scoring pulses, as BCD.
  always_comb begin
    pts = (enm_kill  ? PTS_ENM_KILL  : 32'd0) +
          (boss_hit  ? PTS_BOSS_HIT  : 32'd0) +
          (boss_dead ? PTS_BOSS_DEAD : 32'd0);
    inc_bcd = points_to_bcd(pts);
  end

  bcd_score_add u_score_add (
    .score  (score_q),
    .inc    (inc_bcd),
    .result (score_sum)
  );

  // Invincibility timer next value: cleared on game start, loaded on a hit, else ticks down.
  always_comb begin
    timer_nxt = timer;
    if ((state == SCENE_TITLE) && start_pulse) begin
      timer_nxt = '0;
    end else if (hit_ok) begin
      timer_nxt = TIMER_W'(INV_FRAMES);
    end else if (frame_tick && (timer != '0)) begin
      timer_nxt = timer - TIMER_W'(1);
    end
  end

  // Sprite visibility for the coming cycle while staying in PLAY.
  always_comb begin
`ifdef GSC_INVULN_BLINK_EN
    vis_nxt = (timer_nxt == '0) | timer_nxt[3];
`else
    vis_nxt = 1'b1;
`endif
  end

  // Invincibility timer register.
  always_ff @(posedge clk_25m) begin
    if (rst) timer <= '0;
    else     timer <= timer_nxt;
  end

  // Scene FSM with registered life, score, sprite enable and object-generator reset.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state    <= SCENE_TITLE;
      life     <= 2'd0;
      score_q  <= '0;
      reimuE   <= 1'b0;
      game_rst <= 1'b0;
    end else begin
      game_rst <= 1'b0;
      reimuE   <= 1'b0;
      case (state)
        SCENE_TITLE: begin
          if (start_pulse) begin
            state    <= SCENE_PLAY;
            life     <= 2'(MAX_LIFE);
            score_q  <= '0;
            game_rst <= 1'b1;
            reimuE   <= 1'b1;
          end
        end
        SCENE_PLAY: begin
          score_q <= score_sum;
          if (boss_dead) begin
            state <= SCENE_WIN;
          end else if (hit_ok) begin
            life <= life - 2'd1;
            if (life == 2'd1) state  <= SCENE_LOSE;
            else              reimuE <= vis_nxt;
          end else begin
            reimuE <= vis_nxt;
          end
        end
        SCENE_WIN, SCENE_LOSE: begin
          if (start_pulse) begin
            state    <= SCENE_TITLE;
            game_rst <= 1'b1;
          end
        end
        default: state <= SCENE_TITLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: vector table, directed scenarios and random stimulus
// against an integer-level reference of the game rules.
module tb_game_state_ctrl;

  logic       clk_25m = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       enm_kill = 1'b0;
  logic       boss_hit = 1'b0;
  logic       boss_dead = 1'b0;
  logic       player_hit = 1'b0;
  logic [1:0] scene;
  logic [1:0] life;
  logic [3:0] score0, score1, score2, score3;
  logic       reimuE;
  logic       game_rst;

  int errors = 0;
  int checks = 0;

  localparam int SC_TITLE = 0, SC_PLAY = 1, SC_WIN = 2, SC_LOSE = 3;

`ifdef GSC_INVULN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  game_state_ctrl dut (
    .clk_25m    (clk_25m),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .enm_kill   (enm_kill),
    .boss_hit   (boss_hit),
    .boss_dead  (boss_dead),
    .player_hit (player_hit),
    .scene      (scene),
    .life       (life),
    .score0     (score0),
    .score1     (score1),
    .score2     (score2),
    .score3     (score3),
    .reimuE     (reimuE),
    .game_rst   (game_rst)
  );

  always #20 clk_25m = ~clk_25m;

  // reference model state
  int m_scene, m_life, m_score, m_timer;
  bit m_reimu, m_grst, m_prev, m_armed;

  function automatic int dut_score();
    return int'(score3) * 1000 + int'(score2) * 100 + int'(score1) * 10 + int'(score0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit start;
    bit loaded;
    int s;
    int pts;
    if (rst) begin
      m_scene = SC_TITLE; m_life = 0; m_score = 0; m_timer = 0;
      m_reimu = 0; m_grst = 0; m_prev = 0; m_armed = 0;
      return;
    end
    start   = m_armed && start_btn && !m_prev;
    m_prev  = start_btn;
    m_armed = 1;
    m_grst  = 0;
    loaded  = 0;
    s       = m_scene;
    if (s == SC_PLAY) begin
      pts = 10 * int'(enm_kill) + int'(boss_hit) + 100 * int'(boss_dead);
      m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
      if (boss_dead) m_scene = SC_WIN;
      else if (player_hit && m_timer == 0) begin
        m_life  = m_life - 1;
        m_timer = 120;
        loaded  = 1;
        if (m_life == 0) m_scene = SC_LOSE;
      end
    end else if (start) begin
      m_grst = 1;
      if (s == SC_TITLE) begin
        m_scene = SC_PLAY; m_life = 3; m_score = 0; m_timer = 0; loaded = 1;
      end else begin
        m_scene = SC_TITLE;
      end
    end
    if (!loaded && frame_tick && m_timer > 0) m_timer = m_timer - 1;
    m_reimu = (m_scene == SC_PLAY) &&
              (m_timer == 0 || !BLINK || ((m_timer / 8) % 2 == 1));
  endtask

  // one clock: model follows the edge, outputs compared 1 time unit later, pulses dropped
  task automatic tick();
    @(posedge clk_25m);
    model_step();
    #1;
    chk("model scene", int'(scene), m_scene);
    chk("model life", int'(life), m_life);
    chk("model score", dut_score(), m_score);
    chk("model reimuE", int'(reimuE), int'(m_reimu));
    chk("model game_rst", int'(game_rst), int'(m_grst));
    frame_tick = 0; enm_kill = 0; boss_hit = 0; boss_dead = 0; player_hit = 0;
  endtask

  task automatic press_start();
    start_btn = 0; tick();
    start_btn = 1; tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1; tick();
    end
  endtask

  typedef struct {
    bit rst, btn, ek, bh, bd, ph;
    int scene, life, score;
    bit reimu, grst;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1,1,0,0,0,0, 0,0,0,  0,0};
    vecs[1]  = '{1,1,0,0,0,0, 0,0,0,  0,0};
    vecs[2]  = '{0,1,0,0,0,0, 0,0,0,  0,0};
    vecs[3]  = '{0,1,0,0,0,0, 0,0,0,  0,0};
    vecs[4]  = '{0,0,0,0,0,0, 0,0,0,  0,0};
    vecs[5]  = '{0,1,0,0,0,0, 1,3,0,  1,1};
    vecs[6]  = '{0,1,0,0,0,0, 1,3,0,  1,0};
    vecs[7]  = '{0,1,1,0,0,0, 1,3,10, 1,0};
    vecs[8]  = '{0,1,1,1,0,0, 1,3,21, 1,0};
    vecs[9]  = '{0,0,0,1,0,0, 1,3,22, 1,0};
    vecs[10] = '{0,0,0,0,0,1, 1,2,22, 1,0};
    vecs[11] = '{0,0,0,0,0,1, 1,2,22, 1,0};
    vecs[12] = '{0,0,0,0,1,0, 2,2,122,0,0};
    vecs[13] = '{0,1,0,0,0,0, 0,2,122,0,1};
    vecs[14] = '{0,1,1,0,0,0, 0,2,122,0,0};
    vecs[15] = '{0,1,0,0,0,1, 0,2,122,0,0};

    // vector table
    for (int v = 0; v < 16; v++) begin
      rst = vecs[v].rst; start_btn = vecs[v].btn;
      enm_kill = vecs[v].ek; boss_hit = vecs[v].bh;
      boss_dead = vecs[v].bd; player_hit = vecs[v].ph;
      tick();
      chk($sformatf("vec%0d scene", v), int'(scene), vecs[v].scene);
      chk($sformatf("vec%0d life", v), int'(life), vecs[v].life);
      chk($sformatf("vec%0d score", v), dut_score(), vecs[v].score);
      chk($sformatf("vec%0d reimuE", v), int'(reimuE), int'(vecs[v].reimu));
      chk($sformatf("vec%0d game_rst", v), int'(game_rst), int'(vecs[v].grst));
    end

    // game start
    press_start();
    chk("start scene", int'(scene), SC_PLAY);
    chk("start life", int'(life), 3);
    chk("start score", dut_score(), 0);
    chk("start game_rst", int'(game_rst), 1);
    tick();
    chk("start game_rst 1 cycle", int'(game_rst), 0);

    // BCD carry across digits
    for (int i = 0; i < 99; i++) begin enm_kill = 1; tick(); end
    for (int i = 0; i < 5; i++) begin boss_hit = 1; tick(); end
    chk("score 0995", dut_score(), 995);
    enm_kill = 1; boss_hit = 1; tick();
    chk("score 1006", dut_score(), 1006);

    // invincibility window
    player_hit = 1; tick();
    chk("hit1 life", int'(life), 2);
    frames(5);
    player_hit = 1; tick();
    chk("hit during inv life", int'(life), 2);
    frames(114);
    player_hit = 1; tick();
    chk("hit at timer 1 life", int'(life), 2);
    frames(1);
    player_hit = 1; tick();
    chk("hit after 120 frames life", int'(life), 1);
    chk("reimuE timer 120", int'(reimuE), 1);
    frames(1);
    chk("reimuE timer 119", int'(reimuE), BLINK ? 0 : 1);
    frames(119);
    chk("reimuE timer 0", int'(reimuE), 1);

    // boss_dead beats a fatal hit
    player_hit = 1; boss_dead = 1; tick();
    chk("win over fatal hit scene", int'(scene), SC_WIN);
    chk("win over fatal hit life", int'(life), 1);
    chk("win reimuE", int'(reimuE), 0);

    // score held into TITLE, then saturation
    press_start();
    chk("title scene", int'(scene), SC_TITLE);
    chk("title score held", dut_score(), 1106);
    chk("title game_rst", int'(game_rst), 1);
    press_start();
    for (int i = 0; i < 995; i++) begin enm_kill = 1; tick(); end
    chk("score 9950", dut_score(), 9950);
    boss_dead = 1; tick();
    chk("saturate 9999", dut_score(), 9999);
    chk("saturate scene", int'(scene), SC_WIN);

    // reset mid-play
    press_start();
    press_start();
    player_hit = 1; tick();
    for (int i = 0; i < 34; i++) begin enm_kill = 1; tick(); end
    chk("pre-rst life", int'(life), 2);
    chk("pre-rst score", dut_score(), 340);
    rst = 1; enm_kill = 1; player_hit = 1; tick();
    chk("rst scene", int'(scene), SC_TITLE);
    chk("rst life", int'(life), 0);
    chk("rst score", dut_score(), 0);
    chk("rst reimuE", int'(reimuE), 0);
    rst = 0;

    // lose path
    press_start();
    player_hit = 1; tick(); frames(120);
    player_hit = 1; tick(); frames(120);
    player_hit = 1; tick();
    chk("lose scene", int'(scene), SC_LOSE);
    chk("lose life", int'(life), 0);
    chk("lose reimuE", int'(reimuE), 0);
    enm_kill = 1; boss_dead = 1; tick();
    chk("lose score frozen", dut_score(), 0);
    press_start();
    chk("lose->title scene", int'(scene), SC_TITLE);
    chk("lose->title game_rst", int'(game_rst), 1);

    // random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) start_btn = ~start_btn;
      frame_tick = ($urandom_range(0, 1) == 0);
      enm_kill   = ($urandom_range(0, 3) == 0);
      boss_hit   = ($urandom_range(0, 2) == 0);
      boss_dead  = ($urandom_range(0, 149) == 0);
      player_hit = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
